conv_encoder_framed: RTL and testbench

Transmit-side rate-1/2 convolutional encoder with frame handling. It is the encoder that feeds the team's Viterbi decoder.
- Accepts one information bit per cycle under a ready/enable handshake.
- Emits one registered 2-bit code symbol per accepted bit.
- At frame end, automatically appends K-1 zero tail bits so the decoder's trellis terminates in state 0.
- Sits between the bit source and the channel/error-injection stage of the tx/rx harness.

---
 rtl/conv_encoder_framed.sv | 149 ++++++++++++++
 tb/tb_conv_encoder_framed.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_framed.sv
// rtl/conv_encoder_framed.sv - rate-1/2 convolutional encoder with framing and zero-tail termination
module conv_encoder_framed #(
    parameter int             K       = 3,
    parameter logic [K-1:0]   G0      = 3'b111,
    parameter logic [K-1:0]   G1      = 3'b101,
    parameter bit             TAIL_EN = 1'b1,
    parameter int             CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             d_in,
    input  logic             last_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [1:0]       d_out,
    output logic             tail_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] sym_ct_o
);

    localparam int             TCW       = 3;
    localparam logic [TCW-1:0] TAIL_LAST = TCW'(K - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [TCW-1:0]   r_tail_ct;
    logic [TCW-1:0]   w_tail_ct_next;
    logic [K-2:0]     r_sr;
    logic [K-2:0]     w_sr_next;
    logic [K-1:0]     w_v;
    logic [1:0]       w_sym;
    logic             w_ready;
    logic             w_accept;
    logic             w_in_tail;
    logic             w_tail_last;
    logic             w_emit;
    logic             w_bit;
    logic             w_done;
    logic [CNT_W-1:0] w_ct_base;
    logic [CNT_W-1:0] w_ct_next;

    logic             r_valid;
    logic [1:0]       r_d_out;
    logic             r_tail;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_sym_ct;

    // State and tail-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tail_ct <= '0;
        end else begin
            r_state   <= w_state_next;
            r_tail_ct <= w_tail_ct_next;
        end
    end

    // Next-state logic, handshake and frame-end detection
    always_comb begin
        w_state_next   = r_state;
        w_tail_ct_next = '0;
        w_in_tail      = (r_state == S_TAIL);
        w_ready        = !w_in_tail;
        w_accept       = enable_i && w_ready;
        w_tail_last    = w_in_tail && (r_tail_ct == TAIL_LAST);
        w_emit         = w_accept || w_in_tail;
        w_done         = w_tail_last || (w_accept && last_i && !TAIL_EN);
        case (r_state)
            S_IDLE, S_DATA: begin
                if (w_accept) begin
                    if (last_i) begin
                        w_state_next = TAIL_EN ? S_TAIL : S_IDLE;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_TAIL: begin
                if (w_tail_last) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_tail_ct_next = r_tail_ct + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Encoder datapath: tap vector, parities, shifted memory, symbol count
    always_comb begin
        w_bit      = w_in_tail ? 1'b0 : d_in;
        w_v        = '0;
        w_v[K-1]   = w_bit;
        for (int i = 0; i < K - 1; i++) begin
            w_v[K-2-i] = r_sr[i];
        end
        w_sym[1]   = ^(w_v & G0);
        w_sym[0]   = ^(w_v & G1);
        w_sr_next    = r_sr;
        w_sr_next[0] = w_bit;
        for (int i = 1; i < K - 1; i++) begin
            w_sr_next[i] = r_sr[i-1];
        end
        // the count restarts on the cycle following a frame_done pulse
        w_ct_base = r_frame_done ? '0 : r_sym_ct;
        if (w_emit) begin
            w_ct_next = (&w_ct_base) ? w_ct_base : w_ct_base + 1'b1;
        end else begin
            w_ct_next = w_ct_base;
        end
    end

    // Registered symbol outputs and shift-register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr         <= '0;
            r_valid      <= 1'b0;
            r_d_out      <= 2'b00;
            r_tail       <= 1'b0;
            r_frame_done <= 1'b0;
            r_sym_ct     <= '0;
        end else begin
            r_valid      <= w_emit;
            r_tail       <= w_in_tail;
            r_frame_done <= w_done;
            r_sym_ct     <= w_ct_next;
            if (w_emit) begin
                r_sr    <= w_sr_next;
                r_d_out <= w_sym;
            end
        end
    end

    assign ready_o      = w_ready;
    assign valid_o      = r_valid;
    assign d_out        = r_d_out;
    assign tail_o       = r_tail;
    assign frame_done_o = r_frame_done;
    assign sym_ct_o     = r_sym_ct;

endmodule

// File: tb/tb_conv_encoder_framed.sv
// tb/tb_conv_encoder_framed.sv - scoreboard bench for conv_encoder_framed
module tb_conv_encoder_framed;

    typedef struct packed {
        logic [1:0]  sym;
        logic        tail;
        logic        done;
        logic [15:0] ct;
    } sym_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        d = 1'b0;
    logic        last = 1'b0;

    logic        ready_o, valid_o, tail_o, frame_done_o;
    logic [1:0]  d_out;
    logic [15:0] sym_ct_o;
    logic        ready0, valid0, tail0, done0;
    logic [1:0]  d_out0;
    logic [15:0] ct0;

    sym_t exp_q[$];
    sym_t obs_q[$];
    sym_t exp0_q[$];
    sym_t obs0_q[$];

    int checks = 0;
    int failures = 0;

    conv_encoder_framed #(.K(3), .G0(3'b111), .G1(3'b101), .TAIL_EN(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable_i(en), .d_in(d), .last_i(last),
        .ready_o(ready_o), .valid_o(valid_o), .d_out(d_out), .tail_o(tail_o),
        .frame_done_o(frame_done_o), .sym_ct_o(sym_ct_o)
    );

    conv_encoder_framed #(.K(3), .G0(3'b111), .G1(3'b101), .TAIL_EN(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .enable_i(en), .d_in(d), .last_i(last),
        .ready_o(ready0), .valid_o(valid0), .d_out(d_out0), .tail_o(tail0),
        .frame_done_o(done0), .sym_ct_o(ct0)
    );

    always #5 clk = ~clk;

    function automatic sym_t mk(input logic [1:0] s, input logic t, input logic dn, input int c);
        sym_t r;
        r.sym  = s;
        r.tail = t;
        r.done = dn;
        r.ct   = 16'(c);
        return r;
    endfunction

    // advance one clock, then record any symbol each encoder produced
    task automatic tick();
        @(posedge clk);
        #1;
        if (valid_o) obs_q.push_back({d_out, tail_o, frame_done_o, sym_ct_o});
        if (valid0)  obs0_q.push_back({d_out0, tail0, done0, ct0});
    endtask

    task automatic do_reset();
        en = 1'b0; d = 1'b0; last = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        obs_q.delete(); obs0_q.delete(); exp_q.delete(); exp0_q.delete();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ready_o, valid_o, d_out, tail_o, frame_done_o, sym_ct_o} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b vld=%b d=%b tail=%b done=%b ct=%0d exp rdy=1 rest 0",
                     ready_o, valid_o, d_out, tail_o, frame_done_o, sym_ct_o);
        end
        do_reset();
    endtask

    task automatic test_impulse();
        sym_t o, e;
        do_reset();
        en = 1'b1; d = 1'b1; last = 1'b1;
        exp_q.push_back(mk(2'b11, 0, 0, 1));
        exp_q.push_back(mk(2'b10, 1, 0, 2));
        exp_q.push_back(mk(2'b11, 1, 1, 3));
        tick();
        en = 1'b0; d = 1'b0; last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid_o !== 1'b1 || ready_o !== (i == 2)) begin
                failures++;
                $display("FAIL impulse_cycle%0d got vld=%b rdy=%b exp vld=1 rdy=%b", i, valid_o, ready_o, (i == 2));
            end
            if (i < 2) tick();
        end
        tick();
        checks++;
        if (valid_o !== 1'b0 || sym_ct_o !== 16'h0) begin
            failures++;
            $display("FAIL impulse_after got vld=%b ct=%0d exp vld=0 ct=0", valid_o, sym_ct_o);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL impulse_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL impulse_sym got=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_frame(input int gap);
        sym_t o, e;
        logic [3:0] bits;
        bits = 4'b1101;
        do_reset();
        exp_q.push_back(mk(2'b11, 0, 0, 1));
        exp_q.push_back(mk(2'b10, 0, 0, 2));
        exp_q.push_back(mk(2'b00, 0, 0, 3));
        exp_q.push_back(mk(2'b01, 0, 0, 4));
        exp_q.push_back(mk(2'b01, 1, 0, 5));
        exp_q.push_back(mk(2'b11, 1, 1, 6));
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                for (int g = 0; g < gap; g++) begin
                    en = 1'b0;
                    tick();
                    checks++;
                    if (valid_o !== 1'b0 || d_out !== 2'b10) begin
                        failures++;
                        $display("FAIL frame_gap%0d got vld=%b d=%b exp vld=0 d=10", g, valid_o, d_out);
                    end
                end
            end
            en = 1'b1; d = bits[i]; last = (i == 3);
            tick();
        end
        en = 1'b0; d = 1'b0; last = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL frame_count gap=%0d got=%0d exp=%0d", gap, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL frame_sym gap=%0d got=%h exp=%h", gap, o, e);
            end
        end
    endtask

    task automatic test_backpressure();
        sym_t o, e;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(mk(2'b11, 0, 0, 1));
            exp_q.push_back(mk(2'b10, 1, 0, 2));
            exp_q.push_back(mk(2'b11, 1, 1, 3));
        end
        en = 1'b1; d = 1'b1; last = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_return got=%b exp=1", ready_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || ready_o !== 1'b0 || sym_ct_o !== 16'd1) begin
            failures++;
            $display("FAIL bp_immediate_accept got vld=%b rdy=%b ct=%0d exp vld=1 rdy=0 ct=1", valid_o, ready_o, sym_ct_o);
        end
        en = 1'b0; d = 1'b0; last = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL bp_sym got=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        sym_t o, e;
        do_reset();
        exp_q.push_back(mk(2'b11, 0, 0, 1));
        exp_q.push_back(mk(2'b10, 0, 0, 2));
        en = 1'b1; d = 1'b1; last = 1'b0;
        tick();
        d = 1'b0;
        tick();
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ready_o, valid_o, d_out, tail_o, frame_done_o, sym_ct_o} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL midreset_outputs got rdy=%b vld=%b d=%b tail=%b done=%b ct=%0d exp rdy=1 rest 0",
                     ready_o, valid_o, d_out, tail_o, frame_done_o, sym_ct_o);
        end
        tick();
        rst = 1'b0;
        exp_q.push_back(mk(2'b11, 0, 0, 1));
        exp_q.push_back(mk(2'b10, 1, 0, 2));
        exp_q.push_back(mk(2'b11, 1, 1, 3));
        en = 1'b1; d = 1'b1; last = 1'b1;
        tick();
        en = 1'b0; d = 1'b0; last = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL midreset_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL midreset_sym got=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_no_tail();
        sym_t o, e;
        logic [3:0] bits;
        bits = 4'b0011;
        do_reset();
        exp0_q.push_back(mk(2'b11, 0, 0, 1));
        exp0_q.push_back(mk(2'b01, 0, 1, 2));
        exp0_q.push_back(mk(2'b01, 0, 0, 1));
        exp0_q.push_back(mk(2'b11, 0, 1, 2));
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; d = bits[i]; last = (i == 1 || i == 3);
            tick();
            checks++;
            if (ready0 !== 1'b1) begin
                failures++;
                $display("FAIL notail_ready%0d got=%b exp=1", i, ready0);
            end
        end
        en = 1'b0; d = 1'b0; last = 1'b0;
        tick();
        checks++;
        if (obs0_q.size() != exp0_q.size()) begin
            failures++;
            $display("FAIL notail_count got=%0d exp=%0d", obs0_q.size(), exp0_q.size());
        end
        while (exp0_q.size() > 0 && obs0_q.size() > 0) begin
            o = obs0_q.pop_front(); e = exp0_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL notail_sym got=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        sym_t o, e;
        logic s0, s1, b, tl;
        int   m_ct, len;
        do_reset();
        s0 = 1'b0; s1 = 1'b0; m_ct = 0;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, 6);
            for (int j = 0; j < len + 2; j++) begin
                tl = (j >= len);
                b  = tl ? 1'b0 : 1'($urandom_range(0, 1));
                if (!tl && $urandom_range(0, 2) == 0) begin
                    en = 1'b0;
                    tick();
                end
                en = !tl; d = b; last = (j == len - 1);
                m_ct++;
                exp_q.push_back(mk({b ^ s0 ^ s1, b ^ s1}, tl, (j == len + 1), m_ct));
                if (j == len + 1) m_ct = 0;
                s1 = s0;
                s0 = b;
                tick();
            end
            en = 1'b0; last = 1'b0;
        end
        tick();
        tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_sym got=%h exp=%h", o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_frame(0);
        test_frame(3);
        test_backpressure();
        test_reset_mid();
        test_no_tail();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
